prv32_branch_unit: RTL and testbench

PRV32_BRANCH_UNIT -- requirements
Module: prv32_branch_unit

---
 rtl/prv32_branch_pkg.sv | 40 ++++
 rtl/prv32_bht.sv | 34 +++
 rtl/prv32_branch_unit.sv | 140 ++++++++++++++
 tb/tb_prv32_branch_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/prv32_branch_pkg.sv
// Shared definitions for the PRV32 branch resolution unit: funct3 encodings,
// flush FSM state type, predictor geometry and the branch condition helper.
package prv32_branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV0 = 3'b010;
    localparam logic [2:0] F3_RSV1 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int BHT_IDX_W   = 4;
    localparam int BHT_ENTRIES = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } stateT;

    // Flags come from an ALU subtract where cf=1 means no borrow (a >= b unsigned).
    function automatic logic condMet(input logic [2:0] funct3,
                                     input logic cf, input logic zf,
                                     input logic vf, input logic sf);
        logic met;
        met = 1'b0;
        case (funct3)
            F3_BEQ:  met = zf;
            F3_BNE:  met = !zf;
            F3_BLT:  met = (sf != vf);
            F3_BGE:  met = (sf == vf);
            F3_BLTU: met = !cf;
            F3_BGEU: met = cf;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/prv32_bht.sv
// 16-entry table of 2-bit saturating counters; lookup reads the registered
// table, so a same-cycle update of the looked-up entry returns the old value.
module prv32_bht
    import prv32_branch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BHT_IDX_W-1:0] lookup_idx,
    output logic                 pred_taken,
    input  logic                 update_en,
    input  logic [BHT_IDX_W-1:0] update_idx,
    input  logic                 update_taken
);

    logic [1:0] ctrTable [BHT_ENTRIES];

    // Entries start weakly not-taken and saturate at 00 / 11.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctrTable[i] <= 2'b01;
            end
        end else if (update_en) begin
            if (update_taken && ctrTable[update_idx] != 2'b11) begin
                ctrTable[update_idx] <= ctrTable[update_idx] + 2'd1;
            end else if (!update_taken && ctrTable[update_idx] != 2'b00) begin
                ctrTable[update_idx] <= ctrTable[update_idx] - 2'd1;
            end
        end
    end

    assign pred_taken = ctrTable[lookup_idx][1];

endmodule

// File: rtl/prv32_branch_unit.sv
// EX-stage branch resolution: condition check, mispredict redirect, IF/ID flush FSM
// and branch statistics. Define PRV32_BHT_EN to build in the 2-bit predictor.
module prv32_branch_unit
    import prv32_branch_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        is_jal_i,
    input  logic        is_jalr_i,
    input  logic [2:0]  funct3_i,
    input  logic        cf_i,
    input  logic        zf_i,
    input  logic        vf_i,
    input  logic        sf_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] target_i,
    input  logic        pred_taken_i,
    input  logic [31:0] fetch_pc_i,
    output logic        pred_taken_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        illegal_o,
    output logic [31:0] taken_cnt_o,
    output logic [31:0] branch_cnt_o
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES);

    stateT       state;
    stateT       stateNext;
    logic [2:0]  flushCnt;
    logic        accept;
    logic        isJump;
    logic        isIllegal;
    logic        isCond;
    logic        actualTaken;
    logic        effPred;
    logic        mispredict;
    logic [31:0] jumpTarget;
    logic [31:0] nextPc;

    assign accept      = valid_i && ready_o;
    assign isJump      = is_jal_i || is_jalr_i;
    assign isIllegal   = !isJump && (funct3_i == F3_RSV0 || funct3_i == F3_RSV1);
    assign isCond      = !isJump && !isIllegal;
    assign actualTaken = isJump || (isCond && condMet(funct3_i, cf_i, zf_i, vf_i, sf_i));
    assign mispredict  = !isIllegal && (actualTaken ^ effPred);
    assign jumpTarget  = is_jalr_i ? {target_i[31:1], 1'b0} : target_i;
    assign nextPc      = actualTaken ? jumpTarget : pc_i + 32'd4;

`ifdef PRV32_BHT_EN
    logic unusedFetchBits;

    assign effPred         = pred_taken_i;
    assign unusedFetchBits = ^{fetch_pc_i[31:6], fetch_pc_i[1:0]};

    prv32_bht u_bht (
        .clk          (clk),
        .rst          (rst),
        .lookup_idx   (fetch_pc_i[5:2]),
        .pred_taken   (pred_taken_o),
        .update_en    (accept && isCond),
        .update_idx   (pc_i[5:2]),
        .update_taken (actualTaken)
    );
`else
    logic unusedPredInputs;

    assign effPred          = 1'b0;
    assign pred_taken_o     = 1'b0;
    assign unusedPredInputs = ^{pred_taken_i, fetch_pc_i};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:  if (accept && mispredict) stateNext = FLUSH;
            FLUSH: if (flushCnt == FLUSH_LAST) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state == IDLE);
        flush_o = (state == FLUSH);
    end

    // flushCnt numbers the FLUSH cycles 1..FLUSH_CYCLES so the exit compare is direct.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flushCnt <= 3'd0;
        end else if (state == IDLE) begin
            flushCnt <= (accept && mispredict) ? 3'd1 : 3'd0;
        end else if (flushCnt == FLUSH_LAST) begin
            flushCnt <= 3'd0;
        end else begin
            flushCnt <= flushCnt + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_o    <= 1'b0;
            illegal_o     <= 1'b0;
            redirect_pc_o <= 32'd0;
        end else begin
            redirect_o <= accept && mispredict;
            illegal_o  <= accept && isIllegal;
            if (accept && mispredict) begin
                redirect_pc_o <= nextPc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_o <= 32'd0;
            taken_cnt_o  <= 32'd0;
        end else if (accept && isCond) begin
            branch_cnt_o <= branch_cnt_o + 32'd1;
            if (actualTaken) begin
                taken_cnt_o <= taken_cnt_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_prv32_branch_unit.sv
// Scoreboard bench for prv32_branch_unit: a behavioural model predicts every
// cycle's outputs, a monitor process compares them against the DUT.
module tb_prv32_branch_unit;

    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, ready_o, is_jal_i, is_jalr_i;
    logic [2:0]  funct3_i;
    logic        cf_i, zf_i, vf_i, sf_i;
    logic [31:0] pc_i, target_i, fetch_pc_i;
    logic        pred_taken_i, pred_taken_o;
    logic        redirect_o, flush_o, illegal_o;
    logic [31:0] redirect_pc_o, taken_cnt_o, branch_cnt_o;

    always #5 clk = ~clk;

    prv32_branch_unit #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i), .funct3_i(funct3_i),
        .cf_i(cf_i), .zf_i(zf_i), .vf_i(vf_i), .sf_i(sf_i),
        .pc_i(pc_i), .target_i(target_i), .pred_taken_i(pred_taken_i),
        .fetch_pc_i(fetch_pc_i), .pred_taken_o(pred_taken_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .flush_o(flush_o), .illegal_o(illegal_o),
        .taken_cnt_o(taken_cnt_o), .branch_cnt_o(branch_cnt_o)
    );

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic        flush;
        logic        ready;
        logic        illegal;
        logic        pred;
        logic [31:0] bcnt;
        logic [31:0] tcnt;
    } expT;

    expT         expQ[$];
    int          checks = 0;
    int          failures = 0;

    int          flushLeft;
    logic [31:0] mRpc, mBcnt, mTcnt;
    int          bht[16];

    task automatic modelReset();
        flushLeft = 0;
        mRpc  = 32'd0;
        mBcnt = 32'd0;
        mTcnt = 32'd0;
        for (int i = 0; i < 16; i++) bht[i] = 1;
    endtask

    function automatic logic modelPred(input logic [31:0] fpc);
`ifdef PRV32_BHT_EN
        return bht[fpc[5:2]] >= 2;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Drives one cycle of inputs and queues the outputs expected after the next edge.
    task automatic applyStimulus(input logic v, input logic jal, input logic jalr,
                                 input logic [2:0] f3, input logic [3:0] flags,
                                 input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic pred, input logic [31:0] fpc);
        expT  e;
        logic taken, prediction, jump;
        @(negedge clk);
        valid_i = v; is_jal_i = jal; is_jalr_i = jalr; funct3_i = f3;
        {cf_i, zf_i, vf_i, sf_i} = flags;
        pc_i = pc; target_i = tgt; pred_taken_i = pred; fetch_pc_i = fpc;

        e.redirect = 1'b0;
        e.illegal  = 1'b0;
        jump = jal || jalr;
        if (flushLeft > 0) begin
            flushLeft--;
        end else if (v) begin
            if (!jump && (f3 == 3'd2 || f3 == 3'd3)) begin
                e.illegal = 1'b1;
            end else begin
                case (f3)
                    3'd0:    taken = flags[2];
                    3'd1:    taken = !flags[2];
                    3'd4:    taken = flags[0] != flags[1];
                    3'd5:    taken = flags[0] == flags[1];
                    3'd6:    taken = !flags[3];
                    default: taken = flags[3];
                endcase
                if (jump) taken = 1'b1;
`ifdef PRV32_BHT_EN
                prediction = pred;
`else
                prediction = 1'b0;
`endif
                if (!jump) begin
                    mBcnt++;
                    if (taken) mTcnt++;
                    if (taken && bht[pc[5:2]] < 3) bht[pc[5:2]]++;
                    if (!taken && bht[pc[5:2]] > 0) bht[pc[5:2]]--;
                end
                if (taken != prediction) begin
                    e.redirect = 1'b1;
                    mRpc = !taken ? pc + 32'd4 : (jalr ? (tgt & 32'hFFFF_FFFE) : tgt);
                    flushLeft = FLUSH_CYCLES;
                end
            end
        end
        e.rpc   = mRpc;
        e.flush = flushLeft > 0;
        e.ready = flushLeft == 0;
        e.pred  = modelPred(fpc);
        e.bcnt  = mBcnt;
        e.tcnt  = mTcnt;
        expQ.push_back(e);
    endtask

    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("redirect_o", 32'(redirect_o), 32'(e.redirect));
                checkOutput("redirect_pc_o", redirect_pc_o, e.rpc);
                checkOutput("flush_o", 32'(flush_o), 32'(e.flush));
                checkOutput("ready_o", 32'(ready_o), 32'(e.ready));
                checkOutput("illegal_o", 32'(illegal_o), 32'(e.illegal));
                checkOutput("pred_taken_o", 32'(pred_taken_o), 32'(e.pred));
                checkOutput("branch_cnt_o", branch_cnt_o, e.bcnt);
                checkOutput("taken_cnt_o", taken_cnt_o, e.tcnt);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, " ready_o"}, 32'(ready_o), 32'd1);
        checkOutput({tag, " flush_o"}, 32'(flush_o), 32'd0);
        checkOutput({tag, " redirect_o"}, 32'(redirect_o), 32'd0);
        checkOutput({tag, " illegal_o"}, 32'(illegal_o), 32'd0);
        checkOutput({tag, " redirect_pc_o"}, redirect_pc_o, 32'd0);
        checkOutput({tag, " pred_taken_o"}, 32'(pred_taken_o), 32'd0);
        checkOutput({tag, " branch_cnt_o"}, branch_cnt_o, 32'd0);
        checkOutput({tag, " taken_cnt_o"}, taken_cnt_o, 32'd0);
    endtask

    initial begin
        logic [31:0] pc, fpc;
        rst = 1'b1;
        valid_i = 0; is_jal_i = 0; is_jalr_i = 0; funct3_i = 0;
        {cf_i, zf_i, vf_i, sf_i} = 4'b0;
        pc_i = 0; target_i = 0; pred_taken_i = 0; fetch_pc_i = 0;
        modelReset();
        repeat (2) @(negedge clk);
        checkResetState("reset");
        rst = 1'b0;

        // flags argument packs {cf, zf, vf, sf}
        applyStimulus(1, 0, 0, 3'b000, 4'b0100, 32'h100, 32'h140, 0, 32'h100);
        applyStimulus(1, 0, 0, 3'b000, 4'b0100, 32'h100, 32'h140, 0, 32'h100);
        applyStimulus(1, 0, 0, 3'b000, 4'b0100, 32'h100, 32'h140, 0, 32'h100);
        applyStimulus(0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 0, 3'b110, 4'b1000, 32'h200, 32'h240, 0, 32'h200);
        applyStimulus(1, 0, 1, 3'b000, 4'b0000, 32'h300, 32'h2003, 0, 32'h300);
        applyStimulus(0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 32'h0);
        applyStimulus(1, 1, 1, 3'b101, 4'b0000, 32'h310, 32'h4001, 0, 32'h310);
        applyStimulus(0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 0, 3'b010, 4'b0100, 32'h400, 32'h440, 1, 32'h400);
        applyStimulus(1, 0, 0, 3'b011, 4'b0100, 32'h404, 32'h440, 0, 32'h404);
        applyStimulus(1, 0, 0, 3'b000, 4'b0000, 32'hFFFF_FFFC, 32'h80, 1, 32'h0);
        applyStimulus(0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 32'h0);
        applyStimulus(0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 32'h0);

        // Same PC taken twice: predictor entry walks 01 -> 10 -> 11.
        applyStimulus(1, 0, 0, 3'b001, 4'b0000, 32'h520, 32'h600, 0, 32'h520);
        repeat (2) applyStimulus(0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 32'h520);
        applyStimulus(1, 0, 0, 3'b001, 4'b0000, 32'h520, 32'h600, 1, 32'h520);
        repeat (2) applyStimulus(0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 32'h520);
        applyStimulus(1, 0, 0, 3'b001, 4'b0100, 32'h520, 32'h600, 1, 32'h520);
        repeat (2) applyStimulus(0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 32'h520);

        // Reset in the first FLUSH cycle aborts the flush.
        applyStimulus(1, 1, 0, 3'b000, 4'b0000, 32'h700, 32'h900, 0, 32'h700);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkResetState("midflush");
        rst = 1'b0;
        modelReset();
        repeat (3) applyStimulus(0, 0, 0, 3'b000, 4'b0000, 32'h0, 32'h0, 0, 32'h0);

        repeat (400) begin
            pc  = 32'h1000 + 32'($urandom_range(15) << 2);
            fpc = 32'h1000 + 32'($urandom_range(15) << 2);
            applyStimulus($urandom_range(9) < 7, $urandom_range(9) == 0, $urandom_range(9) == 0,
                          3'($urandom), 4'($urandom), pc, $urandom, 1'($urandom), fpc);
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
